// File: rtl/ec1_pkg.sv
// Shared encodings for the EC-1 accumulator CPU: opcodes, control-FSM states
// and the A-source select codes used by the control unit and the datapath mux.
package ec1_pkg;

  typedef enum logic [2:0] {
    OpLoad  = 3'b000,
    OpStore = 3'b001,
    OpAdd   = 3'b010,
    OpSub   = 3'b011,
    OpInput = 3'b100,
    OpJz    = 3'b101,
    OpJpos  = 3'b110,
    OpHalt  = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd3,
    StStore  = 4'd4,
    StAdd    = 4'd5,
    StSub    = 4'd6,
    StInWait = 4'd7,
    StInLoad = 4'd8,
    StInRel  = 4'd9,
    StJz     = 4'd10,
    StJpos   = 4'd11,
    StHalt   = 4'd12
  } state_e;

  localparam logic [1:0] ASEL_ALU  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_RAM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

endpackage

// File: rtl/ec1_control_unit.sv
// Fetch/decode/execute sequencer for the EC-1 accumulator datapath. Moore
// outputs except PCload in JZ/JPOS, which follows the accumulator flags.
module ec1_control_unit
  import ec1_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       enter,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       halt,
  output logic [3:0] state
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StStart;
    case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (opcode_e'(IR75))
          OpLoad:  state_d = StLoad;
          OpStore: state_d = StStore;
          OpAdd:   state_d = StAdd;
          OpSub:   state_d = StSub;
          OpInput: state_d = StInWait;
          OpJz:    state_d = StJz;
          OpJpos:  state_d = StJpos;
          OpHalt:  state_d = StHalt;
          default: state_d = StStart;
        endcase
      end
      StLoad, StStore, StAdd, StSub, StJz, StJpos: state_d = StStart;
      // Level handshake on enter: one A load per press regardless of hold time.
      StInWait: state_d = enter ? StInLoad : StInWait;
      StInLoad: state_d = StInRel;
      StInRel:  state_d = enter ? StInRel : StStart;
      StHalt:   state_d = StHalt;
      default:  state_d = StStart;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    halt    = 1'b0;
    case (state_q)
      StFetch: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      // Address switches to IR[4:0] a cycle early so RAM data is settled.
      StDecode: Meminst = 1'b1;
      StLoad: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      StStore: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      StAdd: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      StSub: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      StInLoad: begin
        Asel  = ASEL_IN;
        Aload = 1'b1;
      end
      StJz: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      StJpos: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      StHalt:  halt = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
